// File: rtl/secure_reg_pkg.sv
// Shared definitions for the secure register and its request front-end.
package secure_reg_pkg;

    // Request front-end sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3,
        LOCKED  = 3'd4
    } state_e;

    // Only this hardware thread may touch the secure register.
    localparam int unsigned SECURE_TID = 0;

    // Default widths, shared with secure_register.
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_TID_WIDTH  = 4;

endpackage

// File: rtl/secure_reg_access_ctrl.sv
// Request front-end for the thread-gated secure register: accepts one request
// at a time, forwards only thread-0 accesses as single-cycle strobes, answers
// every request with the same latency, and locks out after repeated denials.
module secure_reg_access_ctrl
    import secure_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TID_WIDTH      = DEFAULT_TID_WIDTH,
    parameter int unsigned MAX_DENY       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [TID_WIDTH-1:0]  req_thread_id,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    output logic                  reg_wr_en,
    output logic                  reg_access_en,
    output logic [TID_WIDTH-1:0]  reg_thread_id,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic                  locked
);

    localparam int unsigned DCW = $clog2(MAX_DENY + 1);
    localparam int unsigned LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DCW-1:0] DENY_MAX  = DCW'(MAX_DENY);
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic                  grant_q, grant_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DCW-1:0]        deny_cnt_q, deny_cnt_d;
    logic [LCW-1:0]        lock_cnt_q, lock_cnt_d;

    // State and captured request/response registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            grant_q    <= 1'b0;
            tid_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            deny_cnt_q <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            grant_q    <= grant_d;
            tid_q      <= tid_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            deny_cnt_q <= deny_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs; strobes derive from the
    // state register so they fall as soon as reset asserts.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        grant_d       = grant_q;
        tid_d         = tid_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        deny_cnt_d    = deny_cnt_q;
        lock_cnt_d    = lock_cnt_q;

        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        locked        = 1'b0;
        reg_access_en = 1'b0;
        reg_wr_en     = 1'b0;
        reg_data_in   = '0;
        reg_thread_id = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    tid_d   = req_thread_id;
                    wdata_d = req_wdata;
                    grant_d = (req_thread_id == TID_WIDTH'(SECURE_TID));
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Denied requests pass through here too, strobes held low,
                // so every request sees the same latency.
                reg_access_en = grant_q;
                reg_wr_en     = grant_q & write_q;
                reg_data_in   = wdata_q;
                reg_thread_id = tid_q;
                state_d       = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = (grant_q && !write_q) ? reg_data_out : '0;
                err_d   = !grant_q;
                if (grant_q) begin
                    deny_cnt_d = '0;
                end else if (deny_cnt_q != DENY_MAX) begin
                    deny_cnt_d = deny_cnt_q + DCW'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (deny_cnt_q == DENY_MAX) begin
                        lock_cnt_d = LOCK_LOAD;
                        state_d    = LOCKED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                locked = 1'b1;
                if (lock_cnt_q == '0) begin
                    deny_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - LCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// Self-checking bench for secure_reg_access_ctrl: directed table, hand-written
// corner sequences, then randomized traffic against a reference model.
module tb_secure_reg_access_ctrl;

    localparam int unsigned DW   = 32;
    localparam int unsigned TW   = 4;
    localparam int unsigned MAXD = 3;
    localparam int unsigned LOCK = 16;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [TW-1:0] req_thread_id;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [DW-1:0] reg_data_in;
    logic          reg_wr_en;
    logic          reg_access_en;
    logic [TW-1:0] reg_thread_id;
    logic [DW-1:0] reg_data_out;
    logic          locked;

    secure_reg_access_ctrl #(
        .DATA_WIDTH     (DW),
        .TID_WIDTH      (TW),
        .MAX_DENY       (MAXD),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_thread_id (req_thread_id),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .reg_data_in   (reg_data_in),
        .reg_wr_en     (reg_wr_en),
        .reg_access_en (reg_access_en),
        .reg_thread_id (reg_thread_id),
        .reg_data_out  (reg_data_out),
        .locked        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the secure register: thread-gated, read data one cycle later.
    logic [DW-1:0] reg_mem;
    initial begin
        reg_mem      = '0;
        reg_data_out = '0;
    end
    always @(posedge clk) begin
        if (reg_access_en && reg_thread_id == '0) begin
            if (reg_wr_en) reg_mem <= reg_data_in;
            else           reg_data_out <= reg_mem;
        end
    end

    int strobes;
    initial strobes = 0;
    always @(negedge clk) if (reg_access_en) strobes++;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register contents and the count of denials since
    // the last grant or lockout.
    logic [DW-1:0] m_mem;
    int unsigned   m_deny;

    task automatic model_step(input logic w, input logic [TW-1:0] tid, input logic [DW-1:0] wd,
                              output logic [DW-1:0] rd, output logic err, output logic lk);
        lk = 1'b0;
        if (tid == 0) begin
            err    = 1'b0;
            rd     = w ? '0 : m_mem;
            if (w) m_mem = wd;
            m_deny = 0;
        end else begin
            err = 1'b1;
            rd  = '0;
            if (m_deny < MAXD) m_deny++;
            if (m_deny == MAXD) begin
                lk     = 1'b1;
                m_deny = 0;
            end
        end
    endtask

    // One full transaction, starting just after a falling edge.
    task automatic run_txn(input logic w, input logic [TW-1:0] tid, input logic [DW-1:0] wd,
                           input int unsigned stall, input logic [DW-1:0] exp_rd,
                           input logic exp_err, input logic exp_lk);
        int   waited;
        int   s0;
        logic grant;
        logic [DW-1:0] held;
        grant         = (tid == 0);
        s0            = strobes;
        req_valid     = 1'b1;
        req_write     = w;
        req_thread_id = tid;
        req_wdata     = wd;
        waited        = 0;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("issue_access_en", {31'd0, reg_access_en}, {31'd0, grant});
        chk("issue_wr_en", {31'd0, reg_wr_en}, {31'd0, grant & w});
        chk("issue_data_in", reg_data_in, wd);
        chk("issue_thread_id", {28'd0, reg_thread_id}, {28'd0, tid});
        chk("issue_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("capture_access_en", {31'd0, reg_access_en}, 32'd0);
        chk("capture_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        held = rsp_rdata;
        for (int unsigned k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, held);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_access_en", {31'd0, reg_access_en}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("strobe_count", strobes - s0, grant ? 32'd1 : 32'd0);
        if (exp_lk) begin
            // Offer a thread-0 read throughout the lockout; it must not get in.
            s0            = strobes;
            req_valid     = 1'b1;
            req_write     = 1'b0;
            req_thread_id = '0;
            for (int unsigned k = 0; k < LOCK; k++) begin
                @(negedge clk);
                chk("lock_locked", {31'd0, locked}, 32'd1);
                chk("lock_req_ready", {31'd0, req_ready}, 32'd0);
            end
            @(negedge clk);
            chk("unlock_locked", {31'd0, locked}, 32'd0);
            chk("unlock_req_ready", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            #1;
            chk("lock_no_strobe", strobes - s0, 32'd0);
        end else begin
            @(negedge clk);
            chk("idle_locked", {31'd0, locked}, 32'd0);
            chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, reg_wr_en}, 32'd0);
        chk({tag, "_access_en"}, {31'd0, reg_access_en}, 32'd0);
        chk({tag, "_data_in"}, reg_data_in, 32'd0);
        chk({tag, "_thread_id"}, {28'd0, reg_thread_id}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    endtask

    typedef struct {
        logic          w;
        logic [TW-1:0] tid;
        logic [DW-1:0] wdata;
        int unsigned   stall;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic          exp_lk;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        logic          lk;

        n_checks = 0;
        n_fail   = 0;
        m_mem    = '0;
        m_deny   = 0;

        //         w     tid    wdata          stall exp_rd         err   lock
        tbl[0]  = '{1'b1, 4'd0, 32'hDEADBEEF, 0,  32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,        0,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd3, 32'h11111111, 0,  32'h0,        1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'd3, 32'h22222222, 0,  32'h0,        1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'd3, 32'h33333333, 0,  32'h0,        1'b1, 1'b1};
        tbl[5]  = '{1'b0, 4'd5, 32'h0,        0,  32'h0,        1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'd2, 32'h44444444, 1,  32'h0,        1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 32'h0,        0,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd1, 32'h0,        0,  32'h0,        1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'd7, 32'h55555555, 2,  32'h0,        1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 32'h0,        10, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'd0, 32'hA5A5A5A5, 3,  32'h0,        1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 32'h0,        0,  32'hA5A5A5A5, 1'b0, 1'b0};

        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_thread_id = '0;
        req_wdata     = '0;
        rsp_ready     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            model_step(tbl[i].w, tbl[i].tid, tbl[i].wdata, rd, er, lk);
            run_txn(tbl[i].w, tbl[i].tid, tbl[i].wdata, tbl[i].stall,
                    tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lk);
        end

        // One denial outstanding, then reset during ISSUE of a thread-0 write.
        model_step(1'b0, 4'd9, '0, rd, er, lk);
        run_txn(1'b0, 4'd9, '0, 0, rd, er, lk);
        req_valid     = 1'b1;
        req_write     = 1'b1;
        req_thread_id = '0;
        req_wdata     = 32'h12345678;
        chk("rst_seq_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst_seq_issue_access", {31'd0, reg_access_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(negedge clk);
        rst_n  = 1'b1;
        m_deny = 0;
        @(negedge clk);
        // Aborted write must not have landed; deny count restarted from zero.
        model_step(1'b0, 4'd0, '0, rd, er, lk);
        run_txn(1'b0, 4'd0, '0, 0, rd, er, lk);
        for (int i = 0; i < 2; i++) begin
            model_step(1'b1, 4'd6, 32'h0BAD0BAD, rd, er, lk);
            run_txn(1'b1, 4'd6, 32'h0BAD0BAD, 0, rd, er, lk);
        end

        for (int i = 0; i < 200; i++) begin
            logic          w;
            logic [TW-1:0] tid;
            logic [DW-1:0] wd;
            int unsigned   st;
            tid = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 15));
            w   = 1'($urandom_range(0, 1));
            wd  = $urandom;
            st  = $urandom_range(0, 2);
            model_step(w, tid, wd, rd, er, lk);
            run_txn(w, tid, wd, st, rd, er, lk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
